// File: rtl/wide_add_pkg.sv
// Shared types for the wide add sequencer: controller state encoding.
package wide_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : wide_add_pkg

// File: rtl/adder_nbit.sv
// Narrow ripple adder shared by the sequencer; one chunk per use.
module adder_nbit #(
  parameter int BIT_WIDTH = 4
) (
  input  logic [BIT_WIDTH-1:0] a,
  input  logic [BIT_WIDTH-1:0] b,
  input  logic                 carry_in,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 overflow
);

  // Widen by one bit so the carry out lands in the top bit of the result.
  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{BIT_WIDTH{1'b0}}, carry_in};

endmodule : adder_nbit

// File: rtl/wide_add_sequencer.sv
// Wide adder built from one narrow adder, stepping LSB chunk first with a
// registered carry between chunks. Result and overflow only update on entry
// to DONE so partial sums never reach the outputs.
module wide_add_sequencer #(
  parameter int BIT_WIDTH  = 4,
  parameter int NUM_CHUNKS = 4
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            start,
  input  logic [BIT_WIDTH*NUM_CHUNKS-1:0] a_in,
  input  logic [BIT_WIDTH*NUM_CHUNKS-1:0] b_in,
  input  logic                            carry_in,
  output logic                            busy,
  output logic                            done,
  output logic [BIT_WIDTH*NUM_CHUNKS-1:0] sum_out,
  output logic                            overflow
);

  import wide_add_pkg::*;

  localparam int TW = BIT_WIDTH * NUM_CHUNKS;
  localparam int CW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(NUM_CHUNKS - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   a_q, a_d;
  logic [TW-1:0]   b_q, b_d;
  logic [TW-1:0]   part_q, part_d;
  logic [TW-1:0]   sum_q, sum_d;
  logic            carry_q, carry_d;
  logic            ovf_q, ovf_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [BIT_WIDTH-1:0] add_a, add_b, add_sum;
  logic                 add_ovf;
  logic                 accept;
  logic                 last_chunk;

  // A request is taken whenever the adder is not mid-sum (IDLE or DONE).
  assign accept     = start && (state_q != ADD);
  assign last_chunk = (cnt_q == LAST_CNT);

  assign add_a = a_q[cnt_q*BIT_WIDTH +: BIT_WIDTH];
  assign add_b = b_q[cnt_q*BIT_WIDTH +: BIT_WIDTH];

  adder_nbit #(
    .BIT_WIDTH(BIT_WIDTH)
  ) u_adder (
    .a       (add_a),
    .b       (add_b),
    .carry_in(carry_q),
    .sum     (add_sum),
    .overflow(add_ovf)
  );

  // State register and all datapath flops; everything clears on reset.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> ADD on start, ADD -> DONE after last chunk,
  // DONE -> ADD on a back-to-back start, else back to IDLE.
  always_comb begin
    // NOTE: default first so no path through the case leaves state_d unassigned (no latch).
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last_chunk) state_d = DONE;
      DONE:    state_d = start ? ADD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load operands on accept, otherwise fold one chunk per ADD cycle.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = a_in;
      b_d     = b_in;
      carry_d = carry_in;
      cnt_d   = '0;
      part_d  = '0;
    end else if (state_q == ADD) begin
      part_d[cnt_q*BIT_WIDTH +: BIT_WIDTH] = add_sum;
      carry_d = add_ovf;
      if (last_chunk) begin
        // Publish the full result, including the chunk computed this cycle.
        sum_d = part_d;
        ovf_d = add_ovf;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Output decode: handshake flags follow the state directly.
  always_comb begin
    busy = (state_q == ADD);
    done = (state_q == DONE);
  end

  assign sum_out  = sum_q;
  assign overflow = ovf_q;

endmodule : wide_add_sequencer

// File: tb/tb_wide_add_sequencer.sv
// Directed and random checks of wide_add_sequencer at 4x4 bits.
module tb_wide_add_sequencer;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        start;
  logic [15:0] a_in, b_in;
  logic        carry_in;
  logic        busy, done, overflow;
  logic [15:0] sum_out;

  int          tests = 0;
  int          fails = 0;
  logic [15:0] prev_sum = '0;
  logic [16:0] ref_sum;
  logic [15:0] ra, rb;
  logic        rc;

  always #5 clk = ~clk;

  wide_add_sequencer #(
    .BIT_WIDTH (4),
    .NUM_CHUNKS(4)
  ) dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .start   (start),
    .a_in    (a_in),
    .b_in    (b_in),
    .carry_in(carry_in),
    .busy    (busy),
    .done    (done),
    .sum_out (sum_out),
    .overflow(overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge: issues one request, follows it to DONE and checks it.
  task automatic do_sum(input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic [15:0] exp_s, input logic exp_o, input string tag);
    int n;
    a_in = a; b_in = b; carry_in = cin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in = 16'($urandom); b_in = 16'($urandom); carry_in = 1'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 12) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " hold"}, 32'(sum_out), 32'(prev_sum));
      n++;
      @(negedge clk);
    end
    check({tag, " latency"}, n, 32'd4);
    check({tag, " sum"}, 32'(sum_out), 32'(exp_s));
    check({tag, " ovf"}, 32'(overflow), 32'(exp_o));
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    prev_sum = exp_s;
  endtask

  initial begin
    n_rst = 1'b0; start = 1'b0; a_in = '0; b_in = '0; carry_in = 1'b0;
    #1;
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst sum", 32'(sum_out), 32'd0);
    check("rst ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);
    check("idle done", 32'(done), 32'd0);

    // Simple carry across chunk boundaries.
    do_sum(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, "t1");
    @(negedge clk);
    check("t1 done_pulse", 32'(done), 32'd0);

    // Carry_in ripples through every chunk into overflow.
    do_sum(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, "t2");
    @(negedge clk);

    // Start during ADD is ignored.
    a_in = 16'h1234; b_in = 16'h1111; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a_in = 16'hFFFF; b_in = 16'hFFFF;
    @(negedge clk);
    start = 1'b0; a_in = '0; b_in = '0;
    check("t3 busy c3", 32'(busy), 32'd1);
    @(negedge clk);
    check("t3 busy c4", 32'(busy), 32'd1);
    check("t3 no_early_done", 32'(done), 32'd0);
    @(negedge clk);
    check("t3 done", 32'(done), 32'd1);
    check("t3 sum", 32'(sum_out), 32'h2345);
    check("t3 ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    check("t3 single_done a", 32'(done), 32'd0);
    check("t3 idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("t3 single_done b", 32'(done), 32'd0);

    // Back-to-back with start held high; new operands in the DONE cycle.
    a_in = 16'h8000; b_in = 16'h8000; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    repeat (3) @(negedge clk);
    check("t4 busy c4", 32'(busy), 32'd1);
    @(negedge clk);
    check("t4 done1", 32'(done), 32'd1);
    check("t4 sum1", 32'(sum_out), 32'h0000);
    check("t4 ovf1", 32'(overflow), 32'd1);
    a_in = 16'h0F0F; b_in = 16'h00F1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("t4 reaccept busy", 32'(busy), 32'd1);
    check("t4 reaccept done", 32'(done), 32'd0);
    check("t4 hold", 32'(sum_out), 32'h0000);
    repeat (3) @(negedge clk);
    check("t4 no_early_done", 32'(done), 32'd0);
    @(negedge clk);
    check("t4 done2", 32'(done), 32'd1);
    check("t4 sum2", 32'(sum_out), 32'h1000);
    check("t4 ovf2", 32'(overflow), 32'd0);
    @(negedge clk);
    check("t4 idle", 32'(busy | done), 32'd0);

    // Asynchronous reset during chunk 2 aborts the sum.
    a_in = 16'hABCD; b_in = 16'h1111; carry_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5 busy_before", 32'(busy), 32'd1);
    check("t5 sum_before", 32'(sum_out), 32'h1000);
    #2 n_rst = 1'b0;
    #1;
    check("t5 async busy", 32'(busy), 32'd0);
    check("t5 async done", 32'(done), 32'd0);
    check("t5 async sum", 32'(sum_out), 32'd0);
    check("t5 async ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    check("t5 idle", 32'(busy | done), 32'd0);
    prev_sum = '0;
    do_sum(16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, "t5 fresh");

    // Random regression against a 17-bit reference sum.
    for (int i = 0; i < 1000; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rc = 1'($urandom);
      ref_sum = {1'b0, ra} + {1'b0, rb} + {16'd0, rc};
      do_sum(ra, rb, rc, ref_sum[15:0], ref_sum[16], "rand");
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_wide_add_sequencer

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle wide adder controller. Adds two NUM_CHUNKS*BIT_WIDTH-bit operands by time-multiplexing one adder_nbit instance, one BIT_WIDTH chunk per cycle, LSB chunk first.
- Carry between chunks is held in a register.
- Sits between a requester (start/done handshake) and the shared narrow adder datapath. Trades latency for area when wide sums are needed infrequently.

Parameters:
- BIT_WIDTH, 4, width of the adder_nbit instance (chunk width).
- NUM_CHUNKS, 4, number of chunks per operand. Total width TW = BIT_WIDTH*NUM_CHUNKS.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on rising clk when not busy.
- a_in  input  TW  operand A; sampled only in the start-accept cycle.
- b_in  input  TW  operand B; sampled only in the start-accept cycle.
- carry_in  input  1  initial carry; sampled only in the start-accept cycle.
- busy  output  1  high while a sum is in progress.
- done  output  1  one-cycle pulse when sum_out/overflow hold the new result.
- sum_out  output  TW  registered result of A+B+carry_in (mod 2^TW).
- overflow  output  1  registered carry out of the MSB chunk.

Behaviour:
- Clock and reset: one clock, clk; reset n_rst is asynchronous, active-low.
- Reset values: state IDLE, busy=0, done=0, sum_out=0, overflow=0. Internal operand regs, partial-sum reg, carry reg and chunk counter are all 0.
- States are IDLE, ADD and DONE.
- IDLE:
  - busy=0, done=0.
  - If start=1 at the edge: latch a_in, b_in into operand regs; load carry reg with carry_in; chunk_cnt=0; go to ADD.
- ADD:
  - busy=1.
  - The adder is driven with a=A chunk[chunk_cnt], b=B chunk[chunk_cnt], carry_in=carry reg.
  - Each edge: the partial-sum chunk[chunk_cnt] takes the adder sum; carry reg takes the adder overflow.
  - If chunk_cnt==NUM_CHUNKS-1, go to DONE: sum_out takes the full partial sum including this chunk, and overflow takes this chunk's carry out.
  - Otherwise chunk_cnt increments.
- DONE:
  - done=1 and busy=0 for exactly one cycle.
  - If start=1 at this edge, accept a new request exactly as from IDLE and go to ADD. Otherwise go to IDLE.
- Latency: start accepted at edge 0; done high in the cycle after edge NUM_CHUNKS (NUM_CHUNKS+1 edges after request). Throughput is one sum per NUM_CHUNKS+1 cycles with back-to-back starts.
- start while in ADD is ignored; no queueing and no error flag. Operand inputs are don't-care outside the accept cycle.
- sum_out/overflow change only on entry to DONE and hold until the next DONE or reset. Partial chunks are never visible on sum_out.
- Chunk indexing: chunk k = bits [k*BIT_WIDTH +: BIT_WIDTH].
- chunk_cnt width is $clog2(NUM_CHUNKS), minimum 1. It never exceeds NUM_CHUNKS-1.
- NUM_CHUNKS=1 is legal: ADD lasts one cycle.
- Reset mid-operation: immediately aborts. All outputs return to reset values; the partial result is discarded.
- Datapath rule: sum_out = (A + B + carry_in) mod 2^TW; overflow = bit TW of the same unsigned sum.

Decomposition:
- Shared package wide_add_pkg: state enum typedef (IDLE, ADD, DONE), 2-bit encoding.
- One sub-module: the existing adder_nbit, instantiated once with BIT_WIDTH passed through.
- Controller FSM, counter, operand/partial/carry registers live in wide_add_sequencer. No further sub-modules.

Test Plan (BIT_WIDTH=4, NUM_CHUNKS=4, TW=16):
- Reset, then a_in=16'h00FF, b_in=16'h0001, carry_in=0, start pulse → busy high for 4 cycles; done pulse in 5th cycle; sum_out=16'h0100; overflow=0; sum_out stays 0 before done.
- a_in=16'hFFFF, b_in=16'h0000, carry_in=1 → sum_out=16'h0000, overflow=1 (carry ripples through all 4 chunks).
- Start 16'h1234+16'h1111; at cycle 2 of ADD, assert start with 16'hFFFF+16'hFFFF → ignored. Result 16'h2345, overflow=0, one done pulse only.
- Back-to-back: hold start high with 16'h8000+16'h8000, then change operands to 16'h0F0F+16'h00F1 in the DONE cycle → first done gives 16'h0000/ovf=1; second done 5 cycles later gives 16'h1000/ovf=0.
- Drop n_rst asynchronously (mid-cycle) during chunk 2 of 16'hABCD+16'h1111 → busy, done, sum_out, overflow go to 0 without a clock edge. After release, IDLE; a fresh request completes correctly.
- Random regression, 1000 sums with random carry_in → compare against the 17-bit reference sum at each done.
